// File: rtl/sap_cpu_core.sv
// SAP-style CPU core: internal program RAM, variable-length micro-steps, OUT valid/ready handshake.
// Define SAP_CPU_LOGIC_EN to turn opcodes 9/A into AND/OR; otherwise they execute as NOPs.
module sap_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic              cf,
    output logic              zf
);

    localparam int OP_W = DATA_W - 4;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_AND = 4'h9;
    localparam logic [3:0] OP_OR  = 4'hA;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, ir_q, ir_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [2:0]        step_q, step_d;
    logic              out_valid_q, out_valid_d;
    logic              halted_q, halted_d;
    logic              cf_q, cf_d, zf_q, zf_d;
    logic              sta_we;

    logic [DATA_W-1:0] ram_rdata;
    logic [3:0]        opcode;
    logic [OP_W-1:0]   operand;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W:0]   alu_add, alu_sub;

    assign ram_rdata = mem[mar_q];
    assign opcode    = ir_q[DATA_W-1 -: 4];
    assign operand   = ir_q[OP_W-1:0];
    assign op_addr   = operand[ADDR_W-1:0];

    // SUB uses two's-complement add so the carry-out is the no-borrow flag.
    assign alu_add = {1'b0, a_q} + {1'b0, b_q};
    assign alu_sub = {1'b0, a_q} + {1'b0, ~b_q} + (DATA_W+1)'(1);

    // NOTE: every output of this block is given its hold value first, so no path can infer a latch.
    always_comb begin
        pc_d        = pc_q;
        mar_d       = mar_q;
        a_d         = a_q;
        b_d         = b_q;
        ir_d        = ir_q;
        step_d      = step_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        halted_d    = halted_q;
        cf_d        = cf_q;
        zf_d        = zf_q;
        sta_we      = 1'b0;

        if (run) begin
            case (step_q)
                T0: begin
                    mar_d  = pc_q;
                    step_d = T1;
                end
                T1: begin
                    ir_d   = ram_rdata;
                    pc_d   = pc_q + ADDR_W'(1);
                    step_d = T2;
                end
                T2: begin
                    step_d = T0;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            mar_d  = op_addr;
                            step_d = T3;
                        end
`ifdef SAP_CPU_LOGIC_EN
                        OP_AND, OP_OR: begin
                            mar_d  = op_addr;
                            step_d = T3;
                        end
`endif
                        OP_LDI: a_d = DATA_W'(operand);
                        OP_JMP: pc_d = op_addr;
                        OP_JC:  if (cf_q) pc_d = op_addr;
                        OP_JZ:  if (zf_q) pc_d = op_addr;
                        OP_OUT: begin
                            out_data_d  = a_q;
                            out_valid_d = 1'b1;
                            step_d      = T3;
                        end
                        OP_HLT: begin
                            halted_d = 1'b1;
                            step_d   = T2;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    step_d = T0;
                    case (opcode)
                        OP_LDA: a_d = ram_rdata;
                        OP_ADD, OP_SUB: begin
                            b_d    = ram_rdata;
                            step_d = T4;
                        end
`ifdef SAP_CPU_LOGIC_EN
                        OP_AND, OP_OR: begin
                            b_d    = ram_rdata;
                            step_d = T4;
                        end
`endif
                        OP_STA: sta_we = 1'b1;
                        OP_OUT: begin
                            if (out_valid_q && out_ready) out_valid_d = 1'b0;
                            else                          step_d      = T3;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    step_d = T0;
                    case (opcode)
                        OP_ADD: begin
                            {cf_d, a_d} = alu_add;
                            zf_d        = (alu_add[DATA_W-1:0] == '0);
                        end
                        OP_SUB: begin
                            {cf_d, a_d} = alu_sub;
                            zf_d        = (alu_sub[DATA_W-1:0] == '0);
                        end
`ifdef SAP_CPU_LOGIC_EN
                        OP_AND: begin
                            a_d  = a_q & b_q;
                            cf_d = 1'b0;
                            zf_d = ((a_q & b_q) == '0);
                        end
                        OP_OR: begin
                            a_d  = a_q | b_q;
                            cf_d = 1'b0;
                            zf_d = ((a_q | b_q) == '0);
                        end
`endif
                        default: ;
                    endcase
                end
                default: step_d = T0;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            pc_q        <= '0;
            mar_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ir_q        <= '0;
            step_q      <= T0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            cf_q        <= 1'b0;
            zf_q        <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            mar_q       <= mar_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ir_q        <= ir_d;
            step_q      <= step_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            cf_q        <= cf_d;
            zf_q        <= zf_d;
        end
    end

    // NOTE: the RAM has no reset so the program survives clr_n; reset only blocks writes.
    always_ff @(posedge clk) begin
        if (clr_n) begin
            if (sta_we)               mem[mar_q]     <= a_q;
            else if (prog_we && !run) mem[prog_addr] <= prog_data;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign pc        = pc_q;
    assign cf        = cf_q;
    assign zf        = zf_q;

endmodule

// File: tb/tb_sap_cpu_core.sv
// Bench for sap_cpu_core: directed program table, hand-written handshake/freeze/reset sequences,
// and random programs checked against an instruction-level reference model.
module tb_sap_cpu_core;

    logic       clk = 1'b0;
    logic       clr_n, run, prog_we, out_ready;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] out_data;
    logic       out_valid, halted, cf, zf;
    logic [3:0] pc;

    int tests = 0;
    int fails = 0;

    sap_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .clr_n(clr_n), .run(run), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .halted(halted), .pc(pc), .cf(cf), .zf(zf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] prog [16];
        int         cycles;
        logic [3:0] pc;
        logic       cf;
        logic       zf;
        logic       halted;
        logic [7:0] out;
    } vec_t;

    vec_t       vecs [9];
    logic [7:0] prog_buf [16];

    // Instruction-level reference model.
    logic [3:0] m_pc;
    logic [7:0] m_a, m_out;
    logic       m_cf, m_zf, m_halt;
    logic [7:0] m_ram [16];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [3:0] e_pc, input logic e_cf,
                               input logic e_zf, input logic e_h, input logic [7:0] e_out,
                               input logic e_valid);
        check({name, ".pc"}, 32'(pc), 32'(e_pc));
        check({name, ".cf"}, 32'(cf), 32'(e_cf));
        check({name, ".zf"}, 32'(zf), 32'(e_zf));
        check({name, ".halted"}, 32'(halted), 32'(e_h));
        check({name, ".out_data"}, 32'(out_data), 32'(e_out));
        check({name, ".out_valid"}, 32'(out_valid), 32'(e_valid));
    endtask

    task automatic clear_buf();
        for (int i = 0; i < 16; i++) prog_buf[i] = 8'h00;
    endtask

    task automatic load_and_reset();
        run     = 1'b0;
        prog_we = 1'b1;
        for (int i = 0; i < 16; i++) begin
            prog_addr = 4'(i);
            prog_data = prog_buf[i];
            tick(1);
        end
        prog_we = 1'b0;
        clr_n   = 1'b0;
        tick(1);
        clr_n = 1'b1;
        run   = 1'b1;
    endtask

    task automatic model_reset();
        m_pc = 4'h0; m_a = 8'h00; m_out = 8'h00;
        m_cf = 1'b0; m_zf = 1'b0; m_halt = 1'b0;
        for (int i = 0; i < 16; i++) m_ram[i] = prog_buf[i];
    endtask

    // Executes one instruction; returns its cycle count with out_ready held high.
    task automatic model_exec(output int cyc);
        logic [7:0] ir, mem_val;
        logic [3:0] opr;
        int         t;
        ir      = m_ram[m_pc];
        opr     = ir[3:0];
        mem_val = m_ram[opr];
        m_pc    = m_pc + 4'd1;
        cyc     = 3;
        case (ir[7:4])
            4'h1: begin m_a = mem_val; cyc = 4; end
            4'h2: begin
                t    = int'(m_a) + int'(mem_val);
                m_cf = (t > 255);
                m_a  = 8'(t);
                m_zf = (m_a == 8'h00);
                cyc  = 5;
            end
            4'h3: begin
                m_cf = (m_a >= mem_val);
                m_a  = m_a - mem_val;
                m_zf = (m_a == 8'h00);
                cyc  = 5;
            end
            4'h4: begin m_ram[opr] = m_a; cyc = 4; end
            4'h5: m_a = {4'h0, opr};
            4'h6: m_pc = opr;
            4'h7: if (m_cf) m_pc = opr;
            4'h8: if (m_zf) m_pc = opr;
`ifdef SAP_CPU_LOGIC_EN
            4'h9: begin m_a = m_a & mem_val; m_cf = 1'b0; m_zf = (m_a == 8'h00); cyc = 5; end
            4'hA: begin m_a = m_a | mem_val; m_cf = 1'b0; m_zf = (m_a == 8'h00); cyc = 5; end
`endif
            4'hE: begin m_out = m_a; cyc = 4; end
            4'hF: m_halt = 1'b1;
            default: ;
        endcase
    endtask

    initial begin
        int cyc;

        vecs[0] = '{"demo_add", '{8'h1E,8'h2F,8'hE0,8'hF0,8'h00,8'h00,8'h00,8'h00,
                                  8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'd28,8'd14},
                    16, 4'd4, 1'b0, 1'b0, 1'b1, 8'd42};
        vecs[1] = '{"sub_zero", '{8'h55,8'h3F,8'hF0,8'h00,8'h00,8'h00,8'h00,8'h00,
                                  8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h05},
                    11, 4'd3, 1'b1, 1'b1, 1'b1, 8'h00};
        vecs[2] = '{"sub_borrow", '{8'h53,8'h3F,8'hE0,8'hF0,8'h00,8'h00,8'h00,8'h00,
                                    8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h05},
                    15, 4'd4, 1'b0, 1'b0, 1'b1, 8'hFE};
        vecs[3] = '{"jz_taken", '{8'h55,8'h3F,8'h87,8'h00,8'h00,8'h00,8'h00,8'hF0,
                                  8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h05},
                    11, 4'd7, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[4] = '{"jc_not_taken", '{8'h53,8'h3F,8'h77,8'h00,8'h00,8'h00,8'h00,8'hF0,
                                      8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h05},
                    11, 4'd3, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{"pc_wrap", '{8'h6F,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,
                                 8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    6, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[6] = '{"sta_lda", '{8'h1E,8'h4D,8'h50,8'h1D,8'hE0,8'hF0,8'h00,8'h00,
                                 8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h5A,8'h00},
                    22, 4'd6, 1'b0, 1'b0, 1'b1, 8'h5A};
        vecs[7] = '{"add_overflow", '{8'h1E,8'h2F,8'hE0,8'hF0,8'h00,8'h00,8'h00,8'h00,
                                      8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'hFF,8'h01},
                    16, 4'd4, 1'b1, 1'b1, 1'b1, 8'h00};
`ifdef SAP_CPU_LOGIC_EN
        vecs[8] = '{"and_op", '{8'h1E,8'h2E,8'h1E,8'h9F,8'hE0,8'hF0,8'h00,8'h00,
                                8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'hF0,8'h0F},
                    25, 4'd6, 1'b0, 1'b1, 1'b1, 8'h00};
`else
        vecs[8] = '{"op9_nop", '{8'h1E,8'h2E,8'h1E,8'h9F,8'hE0,8'hF0,8'h00,8'h00,
                                 8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'hF0,8'h0F},
                    23, 4'd6, 1'b1, 1'b0, 1'b1, 8'hF0};
`endif

        clr_n = 1'b1; run = 1'b1; prog_we = 1'b0; out_ready = 1'b1;
        prog_addr = 4'h0; prog_data = 8'h00;

        clr_n = 1'b0;
        tick(1);
        check_state("reset", 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        clr_n = 1'b1;

        for (int v = 0; v < 9; v++) begin
            for (int i = 0; i < 16; i++) prog_buf[i] = vecs[v].prog[i];
            load_and_reset();
            tick(vecs[v].cycles);
            check_state(vecs[v].name, vecs[v].pc, vecs[v].cf, vecs[v].zf,
                        vecs[v].halted, vecs[v].out, 1'b0);
        end

        // OUT backpressure, plus out_ready ignored while frozen.
        clear_buf();
        prog_buf[0] = 8'h59; prog_buf[1] = 8'hE0; prog_buf[2] = 8'hF0;
        out_ready = 1'b0;
        load_and_reset();
        tick(6);
        check_state("bp_rise", 4'd2, 1'b0, 1'b0, 1'b0, 8'h09, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("bp_hold.valid", 32'(out_valid), 32'd1);
            check("bp_hold.data", 32'(out_data), 32'h09);
            check("bp_hold.pc", 32'(pc), 32'd2);
        end
        run = 1'b0; out_ready = 1'b1;
        tick(3);
        check("bp_frozen.valid", 32'(out_valid), 32'd1);
        run = 1'b1;
        tick(1);
        check_state("bp_accept", 4'd2, 1'b0, 1'b0, 1'b0, 8'h09, 1'b0);
        tick(3);
        check_state("bp_next", 4'd3, 1'b0, 1'b0, 1'b1, 8'h09, 1'b0);

        // Reset during OUT wait.
        out_ready = 1'b0;
        load_and_reset();
        tick(7);
        check("rst_wait.valid", 32'(out_valid), 32'd1);
        clr_n = 1'b0;
        tick(1);
        check_state("rst_wait", 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        clr_n = 1'b1; out_ready = 1'b1;

        // Freeze at ADD T3.
        clear_buf();
        prog_buf[0] = 8'h55; prog_buf[1] = 8'h2F; prog_buf[2] = 8'hE0; prog_buf[3] = 8'hF0;
        prog_buf[15] = 8'h03;
        load_and_reset();
        tick(6);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_state("freeze", 4'd2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        end
        run = 1'b1;
        tick(8);
        check("resume.not_yet_halted", 32'(halted), 32'd0);
        tick(1);
        check_state("resume", 4'd4, 1'b0, 1'b0, 1'b1, 8'h08, 1'b0);

        // Random programs against the reference model.
        for (int p = 0; p < 40; p++) begin
            for (int i = 0; i < 16; i++) prog_buf[i] = 8'($urandom);
            load_and_reset();
            model_reset();
            for (int k = 0; k < 20 && !m_halt; k++) begin
                model_exec(cyc);
                tick(cyc);
                check_state($sformatf("rand%0d_i%0d", p, k), m_pc, m_cf, m_zf, m_halt, m_out, 1'b0);
            end
            if (m_halt) begin
                tick(4);
                check_state($sformatf("rand%0d_halt", p), m_pc, m_cf, m_zf, 1'b1, m_out, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sap_cpu_core.md
Name: sap_cpu_core

Overview:
- Parametrised successor to the 4-bit-address, 8-bit SAP-style CPU datapath and control.
- Generalised data and address width, with internal program RAM, variable-length micro-step sequencing (early step reset), conditional jumps on carry and zero, a store instruction, and a valid/ready output port that stalls the core until the output is consumed.
- Sits below the board top level, clocked by the divided CPU clock, and feeds the seven-segment controller through the output handshake.

Parameters:
- DATA_W, 8: data, register and instruction word width; minimum 8. Opcode = instr[DATA_W-1:DATA_W-4]; operand = instr[DATA_W-5:0].
- ADDR_W, 4: PC, MAR and RAM address width; RAM depth 2^ADDR_W; must be ≤ DATA_W-4.

Ports:
- clk, in, 1: CPU clock; all state updates on rising edge.
- clr_n, in, 1: synchronous active-low reset.
- run, in, 1: core clock enable; 0 freezes all core state.
- prog_we, in, 1: program RAM write strobe; honoured only while run=0.
- prog_addr, in, ADDR_W: program write address.
- prog_data, in, DATA_W: program write data.
- out_data, out, DATA_W: output register value.
- out_valid, out, 1: out_data holds an unconsumed value.
- out_ready, in, 1: consumer accepts out_data.
- halted, out, 1: HLT executed.
- pc, out, ADDR_W: program counter, for LEDs.
- cf, out, 1: carry flag.
- zf, out, 1: zero flag.

Behaviour:
- Reset (clr_n=0 at edge): PC, MAR, A, B, IR, step, out_data, out_valid, halted, cf, zf all cleared to 0. RAM contents are not cleared. Reset overrides run, prog_we and any in-flight OUT.
- RAM: 2^ADDR_W x DATA_W; combinational read at MAR; synchronous write.
- Addressing and arithmetic: PC wraps from 2^ADDR_W-1 to 0. Address operands are truncated to ADDR_W bits. Arithmetic is modulo 2^DATA_W.
- Step counter: 3 bits. Every instruction returns step to 0 on its last cycle (no fixed-length padding).
- Fetch, common to all opcodes: T0 MAR<=PC. T1 IR<=RAM[MAR], PC<=PC+1.
- Execute, from T2 (op = operand field):
  - 0 NOP: T2 idle; 3 cycles total.
  - 1 LDA: T2 MAR<=op; T3 A<=RAM[MAR]; 4 cycles.
  - 2 ADD: T2 MAR<=op; T3 B<=RAM[MAR]; T4 {cf,A}<=A+B, zf<=(new A==0); 5 cycles.
  - 3 SUB: as ADD with A+~B+1. cf = no-borrow (1 when A≥B); zf as ADD.
  - 4 STA: T2 MAR<=op; T3 RAM[MAR]<=A; 4 cycles.
  - 5 LDI: T2 A<=zero-extended op; 3 cycles.
  - 6 JMP: T2 PC<=op; 3 cycles.
  - 7 JC: T2 PC<=op if cf=1, else no change; 3 cycles.
  - 8 JZ: as JC using zf.
  - E OUT:
    - T2 out_data<=A, out_valid<=1.
    - T3 waits until out_valid&&out_ready is sampled at an edge; on that edge out_valid<=0 and step<=0.
    - Minimum 4 cycles. out_data is held stable while valid.
  - F HLT: T2 halted<=1. Step holds at 2 with no further state change; only reset exits.
  - 9–D: NOP (see Optional Feature).
- Flags change only on ADD/SUB (and logic ops when enabled). Loads and jumps never modify flags.
- run=0: PC, regs, step, flags and out_valid are frozen; out_ready is ignored (no acceptance); prog_we writes RAM. run=1: prog_we is ignored.
- Simultaneous events: STA and prog_we cannot collide (gated by run). out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: SAP_CPU_LOGIC_EN.
- Defined: opcode 9 AND and opcode A OR. Each does T2 MAR<=op; T3 B<=RAM[MAR]; T4 A<=A&B (A|B), zf<=(result==0), cf<=0; 5 cycles.
- Undefined: opcodes 9 and A execute as 3-cycle NOPs with no flag change.

Test Plan:
- Reset/load: clr_n=0 for 1 cycle with run=1 -> all outputs 0. Then run=0, load RAM[0..]=0x1E,0x2F,0xE0,0xF0, RAM[14]=28, RAM[15]=14, run=1, out_ready=1 -> out_valid pulses with out_data=42; halted=1 after 16 cycles; pc=4.
- SUB/flags: A=5 via LDI, SUB of RAM value 5 -> A=0, zf=1, cf=1. Then LDI 3, SUB 5 -> A=0xFE, cf=0, zf=0.
- Conditional jump: JZ 7 with zf=1 -> pc=7 after 3 cycles. JC 7 with cf=0 -> pc=next, 3 cycles.
- OUT backpressure: out_ready=0 for 10 cycles after out_valid rises -> out_valid and out_data held, pc unchanged. Raise out_ready -> out_valid falls on the next edge, next fetch follows.
- Wrap and STA: PC at 15 executing NOP -> pc=0. STA 3 with A=0x5A -> RAM[3]=0x5A, read back via LDA 3.
- Freeze/reset: run=0 mid-ADD at T3 for 5 cycles -> no state change. clr_n=0 during OUT wait -> out_valid=0, pc=0 next cycle. With SAP_CPU_LOGIC_EN: AND 0xF0&0x0F -> A=0, zf=1, cf=0.
